// File: rtl/lsu_dmem_if_pkg.sv
// Shared definitions for the load/store unit: FSM state encodings, funct3 size codes
// and the access classification helpers used by both the datapath and the aligner.
package lsu_dmem_if_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } ls_size_e;

  // Undefined funct3 codes fall through to a full word access.
  function automatic ls_size_e ls_size(input logic [2:0] f3);
    ls_size_e sz;
    case (f3)
      LS_B, LS_BU: sz = SZ_B;
      LS_H, LS_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (ls_size(f3))
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = a[0];
      default: mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_dmem_if_align.sv
// Combinational lane logic: byte enables and store replication for the bus side,
// byte/half extraction plus sign/zero extension for the load return path.
module lsu_align
  import lsu_dmem_if_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] w_lane;

  assign w_lane = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (ls_size(i_funct3))
      SZ_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_rdata = i_rdata;
    case (i_funct3)
      LS_B:    o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
      LS_BU:   o_rdata = {24'b0, w_lane[7:0]};
      LS_H:    o_rdata = {{16{w_lane[15]}}, w_lane[15:0]};
      LS_HU:   o_rdata = {16'b0, w_lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_if.sv
// Load/store unit front end: request/grant/response sequencing to a word-wide data bus,
// with misalignment trapping and a bus-wait timeout.
//
//  state | meaning
//  IDLE  | waiting for req_valid; stall follows req_valid
//  REQ   | mem_req held with latched we/be/addr/wdata until mem_gnt
//  WAIT  | granted, waiting for mem_rvalid
//  RESP  | done pulse, error flags and rdata presented for one cycle
module lsu_dmem_if
  import lsu_dmem_if_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 stall,
  output logic                 done,
  output logic [XLEN-1:0]      rdata,
  output logic                 err_misalign,
  output logic                 err_access,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e             r_state, w_state_nxt;
  logic                   r_we;
  logic [2:0]             r_funct3;
  logic [ADDR_SIZE-1:0]   r_addr;
  logic [3:0]             r_be;
  logic [XLEN-1:0]        r_wdata;
  logic [XLEN-1:0]        r_rdata;
  logic                   r_err_mis;
  logic                   r_err_acc;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_misalign;
  logic                   w_timeout;
  logic                   w_rsp;
  logic                   w_to_fire;
  logic [2:0]             w_al_f3;
  logic [1:0]             w_al_a;
  logic [3:0]             w_be;
  logic [XLEN-1:0]        w_wdata_lane;
  logic [XLEN-1:0]        w_rdata_ext;

  // The aligner sees the live request while idle and the latched one afterwards.
  assign w_al_f3 = (r_state == LSU_IDLE) ? req_funct3    : r_funct3;
  assign w_al_a  = (r_state == LSU_IDLE) ? req_addr[1:0] : r_addr[1:0];

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_funct3  (w_al_f3),
    .i_addr_lo (w_al_a),
    .i_wdata   (req_wdata),
    .i_rdata   (mem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata_lane),
    .o_rdata   (w_rdata_ext)
  );

  assign w_misalign = is_misaligned(req_funct3, req_addr[1:0]);
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_W'(1));

  // A bus event in the same cycle as the terminal count wins over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_rsp       = 1'b0;
    w_to_fire   = 1'b0;
    case (r_state)
      LSU_IDLE: if (req_valid) w_state_nxt = w_misalign ? LSU_RESP : LSU_REQ;
      LSU_REQ: begin
        if (mem_gnt) begin
          w_state_nxt = mem_rvalid ? LSU_RESP : LSU_WAIT;
          w_rsp       = mem_rvalid;
        end else if (w_timeout) begin
          w_state_nxt = LSU_RESP;
          w_to_fire   = 1'b1;
        end
      end
      LSU_WAIT: begin
        if (mem_rvalid) begin
          w_state_nxt = LSU_RESP;
          w_rsp       = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = LSU_RESP;
          w_to_fire   = 1'b1;
        end
      end
      LSU_RESP: w_state_nxt = LSU_IDLE;
      default:  w_state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= LSU_IDLE;
      r_we      <= 1'b0;
      r_funct3  <= '0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err_mis <= 1'b0;
      r_err_acc <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        LSU_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_addr    <= req_addr;
            r_be      <= w_be;
            r_wdata   <= w_wdata_lane;
            r_err_mis <= w_misalign;
            r_err_acc <= 1'b0;
            r_cnt     <= CNT_W'(TIMEOUT);
          end
        end
        LSU_REQ, LSU_WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          if (w_rsp && !r_we) r_rdata <= w_rdata_ext;
          if (w_to_fire) begin
            r_err_acc <= 1'b1;
            if (!r_we) r_rdata <= '0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign stall        = (r_state == LSU_IDLE) ? req_valid : (r_state != LSU_RESP);
  assign done         = (r_state == LSU_RESP);
  assign err_misalign = done && r_err_mis;
  assign err_access   = done && r_err_acc;
  assign rdata        = r_rdata;
  assign mem_req      = (r_state == LSU_REQ);
  assign mem_we       = r_we;
  assign mem_be       = r_be;
  assign mem_addr     = {r_addr[ADDR_SIZE-1:2], 2'b00};
  assign mem_wdata    = r_wdata;

endmodule
